// File: rtl/mc_ctrl_unit.sv
// Multicycle control unit: main FSM, instruction decoder and ALU decoder for the ARM-subset core.
// Optional divide sequencing is enabled by defining MC_DIV_EN.
module mc_ctrl_unit #(
   parameter int MUL_LAT = 4,
   parameter int ALUC_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       Instr,
   output logic              PCS,
   output logic              NextPC,
   output logic              RegW,
   output logic              MemW,
   output logic              IRWrite,
   output logic              AdrSrc,
   output logic [1:0]        ResultSrc,
   output logic [1:0]        ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        ImmSrc,
   output logic [1:0]        RegSrc,
   output logic [1:0]        FlagW,
   output logic [ALUC_W-1:0] ALUControl,
   output logic              MulStart,
   output logic              WrHi,
   output logic              Busy
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
      S_ALUWB, S_BRANCH, S_MULWAIT, S_MULWBLO, S_MULWBHI
`ifdef MC_DIV_EN
      , S_DIVWAIT
`endif
   } state_e;

   state_e     state_q, st;
   logic [4:0] cnt_q;

   logic [1:0] op;
   logic [5:0] funct;
   logic       is_mul, is_div, dp_nop, dp_arith;
   logic [3:0] dp_alu, mul_alu;
   logic       irw, npc, adr, rw, mw, br, ms, wh, bz;
   logic [1:0] asa, asb, rsrc, fw;
   logic [3:0] alu;
   logic       unused_ok;

   assign op        = Instr[27:26];
   assign funct     = Instr[25:20];
   assign is_mul    = (op == 2'b00) && !funct[5] && (Instr[7:4] == 4'b1001);
   assign mul_alu   = Instr[23] ? (Instr[22] ? 4'b1000 : 4'b0110) : 4'b0100;
   assign unused_ok = ^{Instr[31:28], Instr[19:16], Instr[11:8], Instr[3:0]};
`ifdef MC_DIV_EN
   assign is_div    = (op == 2'b00) && !funct[5] && (funct[4:1] == 4'b1011) && !is_mul;
`else
   assign is_div    = 1'b0;
`endif

   always_comb begin
      dp_alu = 4'b0000;
      dp_nop = 1'b0;
      case (funct[4:1])
         4'b0100: dp_alu = 4'b0000;
         4'b0010: dp_alu = 4'b0001;
         4'b0000: dp_alu = 4'b0010;
         4'b1100: dp_alu = 4'b0011;
         4'b1101: dp_alu = 4'b0101;
`ifdef MC_DIV_EN
         4'b1011: if (!funct[5]) dp_alu = 4'b0111; else dp_nop = 1'b1;
`endif
         default: dp_nop = 1'b1;
      endcase
   end
   assign dp_arith = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_FETCH:  state_q <= S_DECODE;
            S_DECODE: begin
               case (op)
                  2'b01: state_q <= S_MEMADR;
                  2'b10: state_q <= S_BRANCH;
                  2'b11: state_q <= S_FETCH;
                  default: begin
                     if (is_mul) begin
                        state_q <= S_MULWAIT;
                        cnt_q   <= 5'(MUL_LAT - 1);
                     end else if (funct[5]) state_q <= S_EXECI;
                     else                   state_q <= S_EXECR;
                  end
               endcase
            end
            // A divide reads its operands in EXECR, then waits out the divider.
            S_EXECR: begin
`ifdef MC_DIV_EN
               if (is_div) begin
                  state_q <= S_DIVWAIT;
                  cnt_q   <= 5'd31;
               end else state_q <= S_ALUWB;
`else
               state_q <= S_ALUWB;
`endif
            end
            S_EXECI:  state_q <= S_ALUWB;
            S_MEMADR: state_q <= funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_q <= S_MEMWB;
            S_MULWAIT: begin
               if (cnt_q == 5'd0) state_q <= Instr[23] ? S_MULWBLO : S_MULWBHI;
               else               cnt_q   <= cnt_q - 5'd1;
            end
            S_MULWBLO: state_q <= S_MULWBHI;
`ifdef MC_DIV_EN
            S_DIVWAIT: begin
               if (cnt_q == 5'd0) state_q <= S_ALUWB;
               else               cnt_q   <= cnt_q - 5'd1;
            end
`endif
            default: state_q <= S_FETCH;
         endcase
      end
   end

   // Under reset the outputs show FETCH with every strobe masked.
   assign st = reset ? state_q : S_FETCH;

   always_comb begin
      irw = 1'b0; npc = 1'b0; adr = 1'b0; rw = 1'b0; mw = 1'b0; br = 1'b0;
      ms = 1'b0; wh = 1'b0; bz = 1'b0;
      asa = 2'b00; asb = 2'b00; rsrc = 2'b00; fw = 2'b00; alu = 4'b0000;
      case (st)
         S_FETCH:   begin irw = 1'b1; npc = 1'b1; asa = 2'b01; asb = 2'b10; rsrc = 2'b10; end
         S_DECODE:  begin asa = 2'b01; asb = 2'b10; rsrc = 2'b10; ms = is_mul || is_div; end
         S_MEMADR:  asb = 2'b01;
         S_MEMRD:   adr = 1'b1;
         S_MEMWB:   begin rsrc = 2'b01; rw = 1'b1; end
         S_MEMWR:   begin adr = 1'b1; mw = 1'b1; end
         S_EXECR:   begin alu = dp_alu; fw = {funct[0], funct[0] & dp_arith}; end
         S_EXECI:   begin asb = 2'b01; alu = dp_alu; fw = {funct[0], funct[0] & dp_arith}; end
         S_ALUWB:   begin alu = dp_alu; rw = !dp_nop; end
         S_BRANCH:  begin asb = 2'b01; rsrc = 2'b10; br = 1'b1; end
         S_MULWAIT: begin bz = 1'b1; alu = mul_alu; end
         S_MULWBLO: begin bz = 1'b1; alu = mul_alu; rw = 1'b1; end
         S_MULWBHI: begin bz = 1'b1; alu = mul_alu; rw = 1'b1; wh = 1'b1; fw = {funct[0], 1'b0}; end
`ifdef MC_DIV_EN
         S_DIVWAIT: begin bz = 1'b1; alu = dp_alu; end
`endif
         default: ;
      endcase
   end

   assign IRWrite    = irw & reset;
   assign NextPC     = npc & reset;
   assign RegW       = rw & reset;
   assign MemW       = mw & reset;
   assign MulStart   = ms & reset;
   assign FlagW      = fw & {2{reset}};
   assign Busy       = bz & reset;
   assign AdrSrc     = adr;
   assign ALUSrcA    = asa;
   assign ALUSrcB    = asb;
   assign ResultSrc  = rsrc;
   assign WrHi       = wh;
   assign ALUControl = ALUC_W'(alu);
   assign PCS        = ((Instr[15:12] == 4'd15) & RegW) | (br & reset);
   assign ImmSrc     = op;
   assign RegSrc     = {(op == 2'b01) & !funct[0], op == 2'b10};

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Bench for mc_ctrl_unit: directed and random instructions against a per-instruction cycle trace model.
module tb_mc_ctrl_unit;
   localparam int LAT = 4;

   logic clk = 1'b0, reset;
   logic [31:0] Instr;
   logic PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, MulStart, WrHi, Busy;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, FlagW;
   logic [3:0] ALUControl;

   int n_chk = 0, n_fail = 0;
   logic [31:0] exp_q[$];

   mc_ctrl_unit #(.MUL_LAT(LAT), .ALUC_W(4)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .PCS(PCS), .NextPC(NextPC), .RegW(RegW),
      .MemW(MemW), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
      .FlagW(FlagW), .ALUControl(ALUControl), .MulStart(MulStart), .WrHi(WrHi), .Busy(Busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pk(input logic irw, npc, rw, mw, ms, wh, bz, pc,
                                      input logic [1:0] fw, input logic [3:0] al,
                                      input logic [1:0] im, input logic [1:0] rs);
      return {14'd0, irw, npc, rw, mw, ms, wh, bz, pc, fw, al, im, rs};
   endfunction

   function automatic logic [31:0] obs_vec();
      return pk(IRWrite, NextPC, RegW, MemW, MulStart, WrHi, Busy, PCS, FlagW, ALUControl,
                ImmSrc, RegSrc);
   endfunction

   // Expected per-cycle outputs of one instruction, from fetch to last cycle.
   function automatic void build(input logic [31:0] ins);
      logic [1:0] op, im, rs;
      logic [5:0] f;
      logic rd15, s, mul, div, ok;
      logic [3:0] al;
      op = ins[27:26]; f = ins[25:20]; s = f[0]; rd15 = (ins[15:12] == 4'd15);
      im = op; rs = {op == 2'b01 && !f[0], op == 2'b10};
      mul = (op == 2'b00) && !f[5] && (ins[7:4] == 4'b1001);
`ifdef MC_DIV_EN
      div = (op == 2'b00) && !f[5] && (f[4:1] == 4'hB) && !mul;
`else
      div = 1'b0;
`endif
      exp_q.delete();
      exp_q.push_back(pk(1,1,0,0,0,0,0,0,2'b00,4'h0,im,rs));
      exp_q.push_back(pk(0,0,0,0,mul|div,0,0,0,2'b00,4'h0,im,rs));
      if (op == 2'b01) begin
         exp_q.push_back(pk(0,0,0,0,0,0,0,0,2'b00,4'h0,im,rs));
         if (f[0]) begin
            exp_q.push_back(pk(0,0,0,0,0,0,0,0,2'b00,4'h0,im,rs));
            exp_q.push_back(pk(0,0,1,0,0,0,0,rd15,2'b00,4'h0,im,rs));
         end else
            exp_q.push_back(pk(0,0,0,1,0,0,0,0,2'b00,4'h0,im,rs));
      end else if (op == 2'b10) begin
         exp_q.push_back(pk(0,0,0,0,0,0,0,1,2'b00,4'h0,im,rs));
      end else if (op == 2'b00 && mul) begin
         al = !ins[23] ? 4'b0100 : (ins[22] ? 4'b1000 : 4'b0110);
         for (int i = 0; i < LAT; i++) exp_q.push_back(pk(0,0,0,0,0,0,1,0,2'b00,al,im,rs));
         if (ins[23]) exp_q.push_back(pk(0,0,1,0,0,0,1,rd15,2'b00,al,im,rs));
         exp_q.push_back(pk(0,0,1,0,0,1,1,rd15,{s,1'b0},al,im,rs));
      end else if (op == 2'b00 && div) begin
         exp_q.push_back(pk(0,0,0,0,0,0,0,0,{s,1'b0},4'h7,im,rs));
         for (int i = 0; i < 32; i++) exp_q.push_back(pk(0,0,0,0,0,0,1,0,2'b00,4'h7,im,rs));
         exp_q.push_back(pk(0,0,1,0,0,0,0,rd15,2'b00,4'h7,im,rs));
      end else if (op == 2'b00) begin
         ok = 1'b1;
         case (f[4:1])
            4'b0100: al = 4'h0;
            4'b0010: al = 4'h1;
            4'b0000: al = 4'h2;
            4'b1100: al = 4'h3;
            4'b1101: al = 4'h5;
            default: begin al = 4'h0; ok = 1'b0; end
         endcase
         exp_q.push_back(pk(0,0,0,0,0,0,0,0,
                            {s, s & (f[4:1] == 4'b0100 || f[4:1] == 4'b0010)},al,im,rs));
         exp_q.push_back(pk(0,0,ok,0,0,0,0,ok & rd15,2'b00,al,im,rs));
      end
   endfunction

   // Starts at the beginning of a FETCH cycle; returns at the start of the next one.
   task automatic run(input string tag, input logic [31:0] ins);
      Instr = ins;
      build(ins);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         chk($sformatf("%s[%0d]", tag, i), obs_vec(), exp_q[i]);
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [3:0] cmds [6];
      cmds = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hD, 4'h0};
      cmds[5] = 4'($urandom_range(0, 15));
      ins = $urandom;
      ins[31:28] = 4'hE;
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      case ($urandom_range(0, 5))
         0, 1: begin
            ins[27:26] = 2'b00; ins[25] = 1'($urandom_range(0, 1));
            ins[24:21] = cmds[$urandom_range(0, 5)]; ins[4] = 1'b0;
         end
         2: begin
            ins[27:24] = 4'h0; ins[21] = 1'b0; ins[7:4] = 4'b1001;
            if (!ins[23]) ins[22] = 1'b0;
         end
         3: ins[27:26] = 2'b01;
         4: ins[27:26] = 2'b10;
         default: ins[27:26] = 2'b11;
      endcase
      return ins;
   endfunction

   initial begin
      reset = 1'b0;
      Instr = 32'hE0921003;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst_strobe[%0d]", i), obs_vec(), pk(0,0,0,0,0,0,0,0,2'b00,4'h0,2'b00,2'b00));
         chk($sformatf("rst_sel[%0d]", i), {24'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, WrHi},
             {24'd0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0});
         @(posedge clk); #1;
      end
      reset = 1'b1;
      run("adds", 32'hE0921003);
      run("umull", 32'hE0854392);
      run("smulls", 32'hE0D54392);
      run("mul", 32'hE0030192);
      run("ldr", 32'hE591F004);
      run("str", 32'hE5812004);
      run("b", 32'hEA000003);
      run("div", 32'hE1612003);
      run("op11", 32'hEC000000);

      // Reset lands in the second MULWAIT cycle of a UMULL.
      Instr = 32'hE0854392;
      build(Instr);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("abort_pre[%0d]", i), obs_vec(), exp_q[i]);
         @(posedge clk); #1;
      end
      reset = 1'b0;
      @(negedge clk);
      chk("abort_rst", obs_vec(), pk(0,0,0,0,0,0,0,0,2'b00,4'h0,2'b00,2'b00));
      @(posedge clk); #1;
      reset = 1'b1;
      run("abort_post", 32'hEC000000);

      for (int n = 0; n < 60; n++) run($sformatf("rnd%0d", n), rand_instr());

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
